// File: rtl/score_tracker.sv
// Score, pill counter and double-dabble BCD display driver for the maze game.
// Optional high-score tracking and display select: define HIGH_SCORE_EN.
module score_tracker #(
  parameter int         CNT_W       = 14,
  parameter int         DIGITS      = 4,
  parameter logic [3:0] PILL_CODE   = 4'b0010,
  parameter logic [3:0] POWER_CODE  = 4'b0100,
  parameter logic [3:0] GHOST_CODE  = 4'b1000,
  parameter int         PILL_PTS    = 1,
  parameter int         POWER_PTS   = 5,
  parameter int         GHOST_PTS   = 20,
  parameter int         TOTAL_PILLS = 300
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [3:0]            collision_type,
`ifdef HIGH_SCORE_EN
  input  logic                  show_high,
  output logic [CNT_W-1:0]      high_score,
`endif
  output logic [CNT_W-1:0]      score,
  output logic [9:0]            pill_count,
  output logic                  level_done,
  output logic                  bcd_valid,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int               SCORE_MAX   = 10**DIGITS - 1;
  localparam int               BCD_W       = 4 * DIGITS;
  localparam int               SR_W        = BCD_W + CNT_W;
  localparam int               SC_W        = $clog2(CNT_W + 1);
  localparam logic [31:0]      SCORE_MAX_W = 32'(SCORE_MAX);
  localparam logic [CNT_W-1:0] SCORE_MAX_C = CNT_W'(SCORE_MAX);
  localparam logic [9:0]       TOTAL_C     = 10'(TOTAL_PILLS);
  localparam logic [SC_W-1:0]  LAST_SHIFT  = SC_W'(CNT_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_t;

  logic [CNT_W-1:0] score_q, score_d;
  logic [9:0]       pill_count_q, pill_count_d;
  logic             level_done_q, level_done_d;
  logic [3:0]       prev_code_q;
  logic [CNT_W-1:0] src_q, src_d;
  bcd_state_t       state_q, state_d;
  logic             pending_q, pending_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [BCD_W-1:0] digit_q, digit_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [SR_W-1:0]  adj;
  logic [31:0]      pts_w, sum_w;
  logic             new_code, level_full, toggle, change;

`ifdef HIGH_SCORE_EN
  logic [CNT_W-1:0] high_q, high_d;
  logic             show_q;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Scoring: an event is a matching code that was not present last cycle.
  always_comb begin
    new_code     = (collision_type != prev_code_q);
    level_full   = (pill_count_q >= TOTAL_C);
    pts_w        = '0;
    pill_count_d = pill_count_q;
    if (new_code) begin
      if (collision_type == PILL_CODE) begin
        if (!level_full) begin
          pts_w        = 32'(PILL_PTS);
          pill_count_d = pill_count_q + 10'd1;
        end
      end else if (collision_type == POWER_CODE) begin
        if (!level_full) begin
          pts_w        = 32'(POWER_PTS);
          pill_count_d = pill_count_q + 10'd1;
        end
      end else if (collision_type == GHOST_CODE) begin
        pts_w = 32'(GHOST_PTS);
      end
    end
    sum_w   = 32'(score_q) + pts_w;
    score_d = (sum_w > SCORE_MAX_W) ? SCORE_MAX_C : sum_w[CNT_W-1:0];
    if (clear) begin
      score_d      = '0;
      pill_count_d = '0;
    end
    level_done_d = (pill_count_d == TOTAL_C);
  end

  // Display source selection and change detection.
  always_comb begin
`ifdef HIGH_SCORE_EN
    high_d = (score_q > high_q) ? score_q : high_q;
    src_d  = show_high ? high_d : score_d;
    toggle = (show_high != show_q);
`else
    src_d  = score_d;
    toggle = 1'b0;
`endif
    change = (src_d != src_q) || toggle || clear;
  end

  // Add-3 correction on every BCD nibble before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      localparam int LSB = CNT_W + 4 * gi;
      assign adj[LSB+3:LSB] = (sr_q[LSB+3:LSB] >= 4'd5) ? sr_q[LSB+3:LSB] + 4'd3
                                                         : sr_q[LSB+3:LSB];
    end
  endgenerate
  assign adj[CNT_W-1:0] = sr_q[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sr_d      = sr_q;
    sc_d      = sc_q;
    digit_d   = digit_q;
    case (state_q)
      IDLE: begin
        if (change) state_d = LOAD;
      end
      LOAD: begin
        sr_d      = {{BCD_W{1'b0}}, src_q};
        sc_d      = '0;
        state_d   = SHIFT;
        pending_d = change;
      end
      SHIFT: begin
        sr_d = adj << 1;
        sc_d = sc_q + 1'b1;
        if (sc_q == LAST_SHIFT) state_d = DONE;
        if (change) pending_d = 1'b1;
      end
      default: begin
        digit_d = sr_q[SR_W-1 -: BCD_W];
        if (pending_q || change) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    // A new game abandons any conversion in flight and starts over on the new source.
    if (clear) begin
      state_d   = LOAD;
      pending_d = 1'b0;
    end
    bcd_valid_d = (state_d == IDLE) && !pending_d;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      score_q      <= '0;
      pill_count_q <= '0;
      level_done_q <= 1'b0;
      prev_code_q  <= '0;
      src_q        <= '0;
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      sr_q         <= '0;
      sc_q         <= '0;
      digit_q      <= '0;
      bcd_valid_q  <= 1'b1;
`ifdef HIGH_SCORE_EN
      high_q       <= '0;
      show_q       <= 1'b0;
`endif
    end else begin
      score_q      <= score_d;
      pill_count_q <= pill_count_d;
      level_done_q <= level_done_d;
      prev_code_q  <= collision_type;
      src_q        <= src_d;
      state_q      <= state_d;
      pending_q    <= pending_d;
      sr_q         <= sr_d;
      sc_q         <= sc_d;
      digit_q      <= digit_d;
      bcd_valid_q  <= bcd_valid_d;
`ifdef HIGH_SCORE_EN
      high_q       <= high_d;
      show_q       <= show_high;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
      assign hex[7*gi +: 7] = seg7(digit_q[4*gi +: 4]);
    end
  endgenerate

  assign score      = score_q;
  assign pill_count = pill_count_q;
  assign level_done = level_done_q;
  assign bcd_valid  = bcd_valid_q;
`ifdef HIGH_SCORE_EN
  assign high_score = high_q;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: default instance plus a 2-digit, 3-pill instance.
module tb_score_tracker;

  localparam logic [3:0] PILL  = 4'b0010;
  localparam logic [3:0] POWER = 4'b0100;
  localparam logic [3:0] GHOST = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_a, clear_b;
  logic [3:0]  coll_a, coll_b;
  logic [13:0] score_a;
  logic [6:0]  score_b;
  logic [9:0]  pill_a, pill_b;
  logic        done_a, done_b, valid_a, valid_b;
  logic [27:0] hex_a;
  logic [13:0] hex_b;
`ifdef HIGH_SCORE_EN
  logic        show_high_a, show_high_b;
  logic [13:0] high_a;
  logic [6:0]  high_b;
`endif

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  score_tracker dut_a (
    .CLOCK_50(clk), .reset(rst_n), .clear(clear_a), .collision_type(coll_a),
`ifdef HIGH_SCORE_EN
    .show_high(show_high_a), .high_score(high_a),
`endif
    .score(score_a), .pill_count(pill_a), .level_done(done_a),
    .bcd_valid(valid_a), .hex(hex_a)
  );

  score_tracker #(.CNT_W(7), .DIGITS(2), .TOTAL_PILLS(3)) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .clear(clear_b), .collision_type(coll_b),
`ifdef HIGH_SCORE_EN
    .show_high(show_high_b), .high_score(high_b),
`endif
    .score(score_b), .pill_count(pill_b), .level_done(done_b),
    .bcd_valid(valid_b), .hex(hex_b)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] hex4(input int v);
    return {seg((v / 1000) % 10), seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
  endfunction

  function automatic logic [13:0] hex2(input int v);
    return {seg((v / 10) % 10), seg(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
  endtask

  task automatic cyc_a(input logic [3:0] code);
    coll_a = code;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic [3:0] code);
    coll_b = code;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int which, input string tag);
    int n = 0;
    while (((which == 0) ? valid_a : valid_b) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'((which == 0) ? valid_a : valid_b), 64'(1));
  endtask

  initial begin
    rst_n   = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    coll_a  = '0;
    coll_b  = '0;
`ifdef HIGH_SCORE_EN
    show_high_a = 1'b0;
    show_high_b = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_score", 64'(score_a), 64'(0));
    chk("rst_pill", 64'(pill_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_valid", 64'(valid_a), 64'(1));
    chk("rst_hex_a", 64'(hex_a), 64'(hex4(0)));
    chk("rst_hex_b", 64'(hex_b), 64'(hex2(0)));

    // Held pill counts once; display updates exactly CNT_W+2 edges after the event edge
    cyc_a(PILL);
    chk("hold_score_n", 64'(score_a), 64'(1));
    chk("hold_valid_low", 64'(valid_a), 64'(0));
    cyc_a(PILL);
    cyc_a(PILL);
    coll_a = '0;
    repeat (14 - 1) @(negedge clk);
    chk("hold_pill", 64'(pill_a), 64'(1));
    chk("hold_score", 64'(score_a), 64'(1));
    chk("lat_hex_before", 64'(hex_a), 64'(hex4(0)));
    @(negedge clk);
    chk("lat_hex_after", 64'(hex_a), 64'(hex4(1)));
    chk("lat_valid", 64'(valid_a), 64'(1));

    // Mixed pill, power, ghost from a fresh game
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    chk("clr_score", 64'(score_a), 64'(0));
    wait_valid(0, "clr_conv");
    cyc_a(PILL);
    cyc_a('0);
    cyc_a(POWER);
    cyc_a('0);
    cyc_a(GHOST);
    chk("mix_score", 64'(score_a), 64'(26));
    chk("mix_pill", 64'(pill_a), 64'(2));
    chk("mix_valid_low", 64'(valid_a), 64'(0));
    cyc_a('0);
    wait_valid(0, "mix_conv");
    chk("mix_hex", 64'(hex_a), 64'(hex4(26)));

    // Unmatched code is ignored
    cyc_a(4'b0001);
    cyc_a('0);
    chk("nomatch_score", 64'(score_a), 64'(26));
    chk("nomatch_valid", 64'(valid_a), 64'(1));

    // Clear beats a same-cycle pill, then an event lands mid-conversion
    coll_a  = PILL;
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    coll_a  = '0;
    chk("clrprio_score", 64'(score_a), 64'(0));
    chk("clrprio_pill", 64'(pill_a), 64'(0));
    repeat (4) @(negedge clk);
    cyc_a(GHOST);
    chk("pend_score", 64'(score_a), 64'(20));
    cyc_a('0);
    wait_valid(0, "pend_conv");
    chk("pend_hex", 64'(hex_a), 64'(hex4(20)));

`ifdef HIGH_SCORE_EN
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    wait_valid(0, "hs_clr_conv");
    cyc_a(PILL);
    cyc_a('0);
    cyc_a(POWER);
    cyc_a('0);
    cyc_a(GHOST);
    cyc_a('0);
    wait_valid(0, "hs_conv");
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    @(negedge clk);
    chk("hs_score", 64'(score_a), 64'(0));
    chk("hs_high", 64'(high_a), 64'(26));
    wait_valid(0, "hs_zero_conv");
    chk("hs_hex_zero", 64'(hex_a), 64'(hex4(0)));
    show_high_a = 1'b1;
    @(negedge clk);
    chk("hs_toggle_valid", 64'(valid_a), 64'(0));
    wait_valid(0, "hs_show_conv");
    chk("hs_hex", 64'(hex_a), 64'(hex4(26)));
`endif

    // Level completion with TOTAL_PILLS=3
    for (int i = 0; i < 4; i++) begin
      cyc_b(PILL);
      cyc_b('0);
      if (i == 1) chk("lvl_not_done", 64'(done_b), 64'(0));
    end
    chk("lvl_pill", 64'(pill_b), 64'(3));
    chk("lvl_done", 64'(done_b), 64'(1));
    chk("lvl_score", 64'(score_b), 64'(3));
    cyc_b(GHOST);
    chk("lvl_ghost", 64'(score_b), 64'(23));
    cyc_b('0);
    chk("lvl_pill_hold", 64'(pill_b), 64'(3));
    wait_valid(1, "lvl_conv");
    chk("lvl_hex", 64'(hex_b), 64'(hex2(23)));

    // Saturation at 99 on the 2-digit instance
    clear_b = 1'b1;
    @(negedge clk);
    clear_b = 1'b0;
    chk("sat_clr_done", 64'(done_b), 64'(0));
    for (int i = 0; i < 5; i++) begin
      cyc_b(GHOST);
      cyc_b('0);
    end
    chk("sat_score", 64'(score_b), 64'(99));
    wait_valid(1, "sat_conv");
    chk("sat_hex", 64'(hex_b), 64'(hex2(99)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
